// File: rtl/hs32_alu_wb.sv
// HS32 writeback: nzcv flag register, 2-entry register-write skid buffer, condition evaluation.
// Latency 1 cycle ALU->o_valid; o_ready = !skid_valid (registered); optional forwarding under HS32_WB_BYPASS_EN.
module hs32_alu_wb #(
    parameter int          DEPTH    = 2,
    parameter logic [3:0]  FL_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_r,
    input  logic [3:0]  i_fl,
    input  logic [3:0]  i_rd,
    input  logic        i_we_rd,
    input  logic        i_we_fl,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_r,
    output logic [3:0]  o_rd,
    output logic [3:0]  o_flags,
    input  logic [3:0]  i_cond,
    output logic        o_cond_true
`ifdef HS32_WB_BYPASS_EN
    ,
    output logic        o_fwd_valid,
    output logic [3:0]  o_fwd_rd,
    output logic [31:0] o_fwd_r
`endif
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("hs32_alu_wb: DEPTH must be 2");
    end

    logic        r_main_vld;
    logic [31:0] r_main_r;
    logic [3:0]  r_main_rd;
    logic        r_skid_vld;
    logic [31:0] r_skid_r;
    logic [3:0]  r_skid_rd;
    logic [3:0]  r_flags;

    logic w_acc;
    logic w_enq;
    logic w_pop;

    assign o_ready = !r_skid_vld;
    assign w_acc   = i_valid && o_ready && !i_flush;
    assign w_enq   = w_acc && i_we_rd;
    assign w_pop   = r_main_vld && i_ready;

    // Flush outranks pop: a write shown during a flush cycle is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main_vld <= 1'b0;
            r_main_r   <= 32'd0;
            r_main_rd  <= 4'd0;
            r_skid_vld <= 1'b0;
            r_skid_r   <= 32'd0;
            r_skid_rd  <= 4'd0;
        end else if (i_flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_vld) begin
                r_main_r   <= r_skid_r;
                r_main_rd  <= r_skid_rd;
                r_skid_vld <= w_enq;
                if (w_enq) begin
                    r_skid_r  <= i_r;
                    r_skid_rd <= i_rd;
                end
            end else begin
                r_main_vld <= w_enq;
                if (w_enq) begin
                    r_main_r  <= i_r;
                    r_main_rd <= i_rd;
                end
            end
        end else if (!r_main_vld) begin
            r_main_vld <= w_enq;
            if (w_enq) begin
                r_main_r  <= i_r;
                r_main_rd <= i_rd;
            end
        end else if (!r_skid_vld) begin
            r_skid_vld <= w_enq;
            if (w_enq) begin
                r_skid_r  <= i_r;
                r_skid_rd <= i_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= FL_RESET;
        end else if (w_acc && i_we_fl) begin
            r_flags <= i_fl;
        end
    end

    assign o_valid = r_main_vld;
    assign o_r     = r_main_r;
    assign o_rd    = r_main_rd;
    assign o_flags = r_flags;

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        o_cond_true = 1'b0;
        case (i_cond)
            4'h0: o_cond_true = 1'b1;
            4'h1: o_cond_true = w_z;
            4'h2: o_cond_true = !w_z;
            4'h3: o_cond_true = w_c;
            4'h4: o_cond_true = !w_c;
            4'h5: o_cond_true = w_n;
            4'h6: o_cond_true = !w_n;
            4'h7: o_cond_true = w_v;
            4'h8: o_cond_true = !w_v;
            4'h9: o_cond_true = w_c && !w_z;
            4'hA: o_cond_true = !w_c || w_z;
            4'hB: o_cond_true = (w_n == w_v);
            4'hC: o_cond_true = (w_n != w_v);
            4'hD: o_cond_true = !w_z && (w_n == w_v);
            4'hE: o_cond_true = w_z || (w_n != w_v);
            default: o_cond_true = 1'b0;
        endcase
    end

`ifdef HS32_WB_BYPASS_EN
    // Youngest valid entry; masked to zero when empty since entry data persists past flush.
    always_comb begin
        o_fwd_valid = r_main_vld || r_skid_vld;
        o_fwd_rd    = 4'd0;
        o_fwd_r     = 32'd0;
        if (r_skid_vld) begin
            o_fwd_rd = r_skid_rd;
            o_fwd_r  = r_skid_r;
        end else if (r_main_vld) begin
            o_fwd_rd = r_main_rd;
            o_fwd_r  = r_main_r;
        end
    end
`endif

endmodule

// File: tb/tb_hs32_alu_wb.sv
// Bench for hs32_alu_wb: condition table vectors, hand sequences, randomized run against a queue model.
module tb_hs32_alu_wb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid, o_ready;
    logic [31:0] i_r;
    logic [3:0]  i_fl, i_rd;
    logic        i_we_rd, i_we_fl, i_flush;
    logic        o_valid, i_ready;
    logic [31:0] o_r;
    logic [3:0]  o_rd, o_flags, i_cond;
    logic        o_cond_true;
`ifdef HS32_WB_BYPASS_EN
    logic        o_fwd_valid;
    logic [3:0]  o_fwd_rd;
    logic [31:0] o_fwd_r;
`endif

    hs32_alu_wb #(.DEPTH(2), .FL_RESET(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_r(i_r), .i_fl(i_fl), .i_rd(i_rd),
        .i_we_rd(i_we_rd), .i_we_fl(i_we_fl), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_r(o_r), .o_rd(o_rd), .o_flags(o_flags),
        .i_cond(i_cond), .o_cond_true(o_cond_true)
`ifdef HS32_WB_BYPASS_EN
        , .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_r(o_fwd_r)
`endif
    );

    always #5 clk = !clk;

    typedef struct { logic [31:0] r; logic [3:0] rd; } ent_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an in-order queue of pending writes capped at two.
    ent_t        mq[$];
    ent_t        popped[$];
    logic [3:0]  m_flags;
    logic [31:0] m_last_r;
    logic [3:0]  m_last_rd;
    logic        m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return cy;
            4'h4: return !cy;
            4'h5: return n;
            4'h6: return !n;
            4'h7: return v;
            4'h8: return !v;
            4'h9: return cy & !z;
            4'hA: return !cy | z;
            4'hB: return n == v;
            4'hC: return n != v;
            4'hD: return !z & (n == v);
            4'hE: return z | (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_flags   = 4'b0000;
        m_last_r  = 32'd0;
        m_last_rd = 4'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".o_valid"}, o_valid, mq.size() > 0);
        chk({tag, ".o_ready"}, o_ready, mq.size() < 2);
        chk({tag, ".o_r"}, o_r, m_last_r);
        chk({tag, ".o_rd"}, o_rd, m_last_rd);
        chk({tag, ".o_flags"}, o_flags, m_flags);
        chk({tag, ".cond"}, o_cond_true, cond_ref(i_cond, m_flags));
`ifdef HS32_WB_BYPASS_EN
        chk({tag, ".fwd_vld"}, o_fwd_valid, mq.size() > 0);
        chk({tag, ".fwd_rd"}, o_fwd_rd, mq.size() > 0 ? mq[$].rd : 4'd0);
        chk({tag, ".fwd_r"}, o_fwd_r, mq.size() > 0 ? mq[$].r : 32'd0);
`endif
    endtask

    // One clock with the current i_* values; model advanced, all outputs compared at +1.
    task automatic cycle(input string tag);
        logic pop;
        ent_t e;
        if (o_valid && i_ready && !i_flush) begin
            e.r = o_r; e.rd = o_rd;
            popped.push_back(e);
        end
        m_acc = i_valid && (mq.size() < 2) && !i_flush;
        pop   = (mq.size() > 0) && i_ready;
        @(posedge clk);
        if (i_flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_acc && i_we_rd) begin
                e.r = i_r; e.rd = i_rd;
                mq.push_back(e);
            end
            if (m_acc && i_we_fl) m_flags = i_fl;
        end
        if (mq.size() > 0) begin
            m_last_r  = mq[0].r;
            m_last_rd = mq[0].rd;
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic v, input logic [31:0] r, input logic [3:0] rd,
                          input logic we_rd, input logic we_fl, input logic [3:0] fl,
                          input logic fls, input logic rdy);
        i_valid = v; i_r = r; i_rd = rd; i_we_rd = we_rd;
        i_we_fl = we_fl; i_fl = fl; i_flush = fls; i_ready = rdy;
    endtask

    typedef struct { logic [3:0] flags; logic [3:0] cond; logic exp; } cvec_t;

    initial begin
        cvec_t tbl[16];
        tbl[0]  = '{4'b0110, 4'h9, 1'b0};
        tbl[1]  = '{4'b0110, 4'h3, 1'b1};
        tbl[2]  = '{4'b0110, 4'h1, 1'b1};
        tbl[3]  = '{4'b0110, 4'h2, 1'b0};
        tbl[4]  = '{4'b0110, 4'hD, 1'b0};
        tbl[5]  = '{4'b0110, 4'hF, 1'b0};
        tbl[6]  = '{4'b1001, 4'h5, 1'b1};
        tbl[7]  = '{4'b1001, 4'h6, 1'b0};
        tbl[8]  = '{4'b1001, 4'h8, 1'b0};
        tbl[9]  = '{4'b1001, 4'hD, 1'b1};
        tbl[10] = '{4'b1001, 4'hA, 1'b1};
        tbl[11] = '{4'b1000, 4'hC, 1'b1};
        tbl[12] = '{4'b1000, 4'hB, 1'b0};
        tbl[13] = '{4'b1000, 4'hE, 1'b1};
        tbl[14] = '{4'b0010, 4'h9, 1'b1};
        tbl[15] = '{4'b0010, 4'hA, 1'b0};

        set_in(0, 32'd0, 4'd0, 0, 0, 4'd0, 0, 1);
        i_cond  = 4'h0;
        reset_n = 1'b0;
        model_reset();
        #12;
        chk("rst.o_valid", o_valid, 0);
        chk("rst.o_ready", o_ready, 1);
        chk("rst.o_flags", o_flags, 4'b0000);
        chk("rst.o_r", o_r, 0);
        chk("rst.o_rd", o_rd, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Write-through: one cycle in, one cycle visible, gone next
        set_in(1, 32'hDEADBEEF, 4'd5, 1, 0, 4'd0, 0, 1);
        cycle("wt0");
        chk("wt.o_valid", o_valid, 1);
        chk("wt.o_r", o_r, 32'hDEADBEEF);
        chk("wt.o_rd", o_rd, 5);
        set_in(0, 32'd0, 4'd0, 0, 0, 4'd0, 0, 1);
        cycle("wt1");
        chk("wt.drain", o_valid, 0);

        // Condition table: load flags through a flag-only op, then evaluate
        foreach (tbl[k]) begin
            set_in(1, 32'h0, 4'd0, 0, 1, tbl[k].flags, 0, 1);
            i_cond = tbl[k].cond;
            cycle("cond");
            chk("cond.no_write", o_valid, 0);
            chk($sformatf("cond_tbl[%0d]", k), o_cond_true, tbl[k].exp);
        end

        // Stall: A, B fill both entries, C waits until room
        popped.delete();
        set_in(1, 32'hAAAA0001, 4'd1, 1, 0, 4'd0, 0, 0);
        cycle("abc.A");
        set_in(1, 32'hBBBB0002, 4'd2, 1, 0, 4'd0, 0, 0);
        cycle("abc.B");
        chk("abc.full_rdy", o_ready, 0);
        set_in(1, 32'hCCCC0003, 4'd3, 1, 0, 4'd0, 0, 0);
        cycle("abc.Cstall");
        chk("abc.main_is_A", o_r, 32'hAAAA0001);
        i_ready = 1'b1;
        begin
            bit c_in = 0;
            for (int t = 0; t < 10 && !c_in; t++) begin
                cycle("abc.Cpush");
                c_in = m_acc;
            end
            chk("abc.C_accepted", c_in, 1);
        end
        set_in(0, 32'd0, 4'd0, 0, 0, 4'd0, 0, 1);
        for (int t = 0; t < 10 && o_valid; t++) cycle("abc.drain");
        chk("abc.count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("abc.w0", popped[0].r, 32'hAAAA0001);
            chk("abc.w1", popped[1].r, 32'hBBBB0002);
            chk("abc.w2", popped[2].r, 32'hCCCC0003);
        end

        // Flush while full drops the concurrent flag update too
        set_in(1, 32'h11, 4'd3, 1, 0, 4'd0, 0, 0);
        cycle("fl.a");
        set_in(1, 32'h22, 4'd7, 1, 0, 4'd0, 0, 0);
        cycle("fl.b");
`ifdef HS32_WB_BYPASS_EN
        chk("byp.valid", o_fwd_valid, 1);
        chk("byp.rd", o_fwd_rd, 7);
        chk("byp.r", o_fwd_r, 32'h22);
`endif
        set_in(1, 32'h33, 4'd9, 1, 1, 4'b1111, 1, 1);
        cycle("fl.do");
        chk("fl.o_valid", o_valid, 0);
        chk("fl.o_ready", o_ready, 1);
        chk("fl.flags_kept", o_flags, 4'b0010);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            set_in($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 24) == 0,
                   $urandom_range(0, 2) != 0);
            i_cond = 4'($urandom);
            cycle("rnd");
        end

        // Asynchronous reset mid-stream with both entries occupied
        set_in(1, 32'h44, 4'd4, 1, 1, 4'b1011, 0, 0);
        cycle("ar.a");
        set_in(1, 32'h55, 4'd6, 1, 0, 4'd0, 0, 0);
        cycle("ar.b");
        chk("ar.pre_full", o_ready, 0);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("ar.o_valid", o_valid, 0);
        chk("ar.o_ready", o_ready, 1);
        chk("ar.o_flags", o_flags, 4'b0000);
        reset_n = 1'b1;
        set_in(0, 32'd0, 4'd0, 0, 0, 4'd0, 0, 1);
        cycle("ar.post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
